axi1_rd_slave_mem: RTL and testbench
====================================

Name: axi1_rd_slave_mem

Overview:
- Responder (slave) end of the simplified AXI1 write/read interface driven by the axi1 traffic initiator.
- Accepts write bursts terminated by wlast into a small 64-bit memory window at BASE_ADDR.
- Serves fixed-length read bursts with rlast from the same memory.
- Used in simulation and on-board loopback so the initiator can be exercised without the DDR controller.

Parameters:
DATA_W, 64, data width; bytes per beat = DATA_W/8.
ADDR_W, 32, address width.
BASE_ADDR, 32'h08000000, byte address of memory word 0.
DEPTH, 256, number of DATA_W words; power of two.
RD_BURST_LEN, 4, beats returned per read burst; 1..256.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
awaddr_1  in  ADDR_W  write burst start byte address
awvalid_1  in  1  write address valid
awready_1  out  1  write address ready
wdata_1  in  DATA_W  write beat data
wlast_1  in  1  final write beat
wvalid_1  in  1  write data valid
wready_1  out  1  write data ready
araddr_1  in  ADDR_W  read burst start byte address
arvalid_1  in  1  read address valid
arready_1  out  1  read address ready
rdata_1  out  DATA_W  read beat data
rlast_1  out  1  final read beat
rvalid_1  out  1  read data valid
rready_1  in  1  read data ready
addr_err  out  1  sticky: an out-of-window burst was accepted
wr_bursts  out  16  completed write bursts, wraps at 16'hFFFF->0
rd_bursts  out  16  completed read bursts, wraps

Behaviour:
- Reset: all outputs 0, both FSMs idle, counters 0. Memory contents are not reset.
- Index calculation: idx = (addr - BASE_ADDR) >> log2(DATA_W/8), taken modulo DEPTH. Low byte-offset bits are ignored.
- Window: valid when BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8. Checked only at the address handshake.
- Write FSM states:
  - W_IDLE: awready_1=1, wready_1=0. On awvalid_1&awready_1, latch idx and the in-window flag, then go to W_DATA.
  - W_DATA: awready_1=0, wready_1=1. Each wvalid_1&wready_1 beat writes mem[idx] (only if in window), then idx = idx+1 mod DEPTH.
  - A beat with wlast_1 returns the FSM to W_IDLE and increments wr_bursts.
  - A burst length is not bounded; idx wraps.
- Write timing: wready_1 rises the cycle after the AW handshake. Beats presented during W_IDLE are not accepted.
- Read FSM states:
  - R_IDLE: arready_1=1, rvalid_1=0. On handshake, next cycle: rvalid_1=1, rdata_1=mem[idx] (0 if out of window), beat count 0, go to R_DATA.
  - R_DATA: arready_1=0. rlast_1=1 exactly when count == RD_BURST_LEN-1.
  - On a non-last rvalid_1&rready_1, load mem[idx+1] the next cycle with no bubble.
  - On the last accepted beat, next cycle rvalid_1=0, rlast_1=0, go to R_IDLE, and increment rd_bursts.
- Read latency: 1 cycle from the AR handshake to the first rvalid_1. Throughput is 1 beat/cycle.
- Backpressure: while rvalid_1&!rready_1, rdata_1 and rlast_1 are held stable.
- Read and write FSMs are fully independent and may run concurrently.
- Same-cycle write and read-load of the same index: rdata_1 captures the old contents.
- Out of window: writes are dropped and reads return all zeros, but the handshakes complete normally. addr_err is set at the handshake and cleared only by rst.
- Reset mid-burst: the next cycle both FSMs are idle and all valids/readies are 0. A partially written burst keeps its already-written beats.

Decomposition:
- Shared package axi1_pkg:
  - wr_state_t (W_IDLE, W_DATA) and rd_state_t (R_IDLE, R_DATA).
  - BYTES_PER_BEAT and BEAT_SHIFT constants.
  - Default BASE_ADDR.
- Sub-module axi1_slave_ram: DEPTH x DATA_W, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
1. Single beat: AW 0x08000000, then wdata 0x14144141 with wlast -> wready_1 high 1 cycle after the AW handshake; mem[0]=0x14144141; wr_bursts=1; awready_1 back to 1.
2. Burst read: first write mem[0..3]=1,2,3,4, then AR 0x08000000 with rready_1=1 -> rvalid_1 1 cycle after the handshake; rdata 1,2,3,4 on consecutive cycles; rlast_1 only on 4; arready_1=0 throughout; rd_bursts=1.
3. Backpressure: same read with rready_1 toggling 1010... -> each beat held until accepted; 4 beats in order; no duplicated or skipped beats.
4. Window boundary: write to 0x07FFFFF8 -> handshake completes, memory unchanged, addr_err=1. Read at 0x08000800 -> 4 zero beats. Read at 0x080007F8 -> in window.
5. Wrap: 3-beat write at 0x080007F8 with data A,B,C -> mem[255]=A, mem[0]=B, mem[1]=C.
6. Reset during R_DATA after beat 2 -> next cycle rvalid_1=0 and counters 0; arready_1=1 once rst is low; a re-read returns the retained data.

Source files
------------

// File: rtl/axi1_pkg.sv
// Shared types and constants for the AXI1 responder memory and its RAM.
package axi1_pkg;

  typedef enum logic {W_IDLE, W_DATA} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int BYTES_PER_BEAT = DEF_DATA_W / 8;
  localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0800_0000;

  // Byte-offset bits to drop when turning a byte address into a word index.
  function automatic int beat_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi1_slave_ram.sv
// Word memory behind the responder: one synchronous write port, one
// asynchronous read port, contents never reset.
module axi1_slave_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write to raddr is only visible after the edge, so readers see old data.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi1_rd_slave_mem.sv
// AXI1 responder: accepts wlast-terminated write bursts and serves fixed-length
// read bursts from a small memory window at BASE_ADDR.
module axi1_rd_slave_mem
  import axi1_pkg::*;
#(
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
  parameter int                DEPTH        = 256,
  parameter int                RD_BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr_1,
  input  logic              awvalid_1,
  output logic              awready_1,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic              wlast_1,
  input  logic              wvalid_1,
  output logic              wready_1,
  input  logic [ADDR_W-1:0] araddr_1,
  input  logic              arvalid_1,
  output logic              arready_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              rlast_1,
  output logic              rvalid_1,
  input  logic              rready_1,
  output logic              addr_err,
  output logic [15:0]       wr_bursts,
  output logic [15:0]       rd_bursts
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SHIFT = beat_shift(DATA_W);
  localparam int CNT_W = (RD_BURST_LEN > 1) ? $clog2(RD_BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(RD_BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(DEPTH * (DATA_W / 8));

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> SHIFT);
  endfunction

  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < WIN_BYTES);
  endfunction

  wr_state_t         wr_state_q, wr_state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_inwin_q, wr_inwin_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic [15:0]       wr_bursts_q, wr_bursts_d;

  rd_state_t         rd_state_q, rd_state_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              rd_inwin_q, rd_inwin_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       rd_bursts_q, rd_bursts_d;

  logic              addr_err_q, addr_err_d;

  logic              aw_hs, w_hs, ar_hs, r_hs;
  logic [IDX_W-1:0]  aw_idx, ar_idx, rd_raddr;
  logic              aw_inwin, ar_inwin, ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign aw_hs    = awvalid_1 & awready_q;
  assign w_hs     = wvalid_1 & wready_q;
  assign ar_hs    = arvalid_1 & arready_q;
  assign r_hs     = rvalid_q & rready_1;
  assign aw_idx   = addr_idx(awaddr_1);
  assign ar_idx   = addr_idx(araddr_1);
  assign aw_inwin = in_window(awaddr_1);
  assign ar_inwin = in_window(araddr_1);
  assign ram_we   = w_hs & wr_inwin_q;

  // Idle reads look up the incoming address; a busy burst prefetches the next word.
  assign rd_raddr = (rd_state_q == R_IDLE) ? ar_idx : rd_idx_q + 1'b1;

  axi1_slave_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_idx_q),
    .wdata(wdata_1),
    .raddr(rd_raddr),
    .rdata(ram_rdata)
  );

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_inwin_d  = wr_inwin_q;
    wr_bursts_d = wr_bursts_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          wr_state_d = W_DATA;
          wr_idx_d   = aw_idx;
          wr_inwin_d = aw_inwin;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (wlast_1) begin
            wr_state_d  = W_IDLE;
            wr_bursts_d = wr_bursts_q + 16'd1;
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE);
    wready_d  = (wr_state_d == W_DATA);
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_idx_d    = rd_idx_q;
    rd_inwin_d  = rd_inwin_q;
    rd_cnt_d    = rd_cnt_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rdata_d     = rdata_q;
    rd_bursts_d = rd_bursts_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_DATA;
          rd_idx_d   = ar_idx;
          rd_inwin_d = ar_inwin;
          rd_cnt_d   = '0;
          rvalid_d   = 1'b1;
          rlast_d    = (LAST_CNT == '0);
          rdata_d    = ar_inwin ? ram_rdata : '0;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rd_state_d  = R_IDLE;
            rvalid_d    = 1'b0;
            rlast_d     = 1'b0;
            rd_bursts_d = rd_bursts_q + 16'd1;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            rlast_d  = (rd_cnt_d == LAST_CNT);
            rdata_d  = rd_inwin_q ? ram_rdata : '0;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  assign addr_err_d = addr_err_q | (aw_hs & ~aw_inwin) | (ar_hs & ~ar_inwin);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q  <= W_IDLE;
      wr_idx_q    <= '0;
      wr_inwin_q  <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      wr_bursts_q <= '0;
      rd_state_q  <= R_IDLE;
      rd_idx_q    <= '0;
      rd_inwin_q  <= 1'b0;
      rd_cnt_q    <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      rd_bursts_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_idx_q    <= wr_idx_d;
      wr_inwin_q  <= wr_inwin_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      wr_bursts_q <= wr_bursts_d;
      rd_state_q  <= rd_state_d;
      rd_idx_q    <= rd_idx_d;
      rd_inwin_q  <= rd_inwin_d;
      rd_cnt_q    <= rd_cnt_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rdata_q     <= rdata_d;
      rd_bursts_q <= rd_bursts_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign awready_1 = awready_q;
  assign wready_1  = wready_q;
  assign arready_1 = arready_q;
  assign rvalid_1  = rvalid_q;
  assign rlast_1   = rlast_q;
  assign rdata_1   = rdata_q;
  assign addr_err  = addr_err_q;
  assign wr_bursts = wr_bursts_q;
  assign rd_bursts = rd_bursts_q;

endmodule

// File: tb/tb_axi1_rd_slave_mem.sv
// Self-checking bench for axi1_rd_slave_mem: an operation table of write and
// read bursts with expected beats, a read-beat scoreboard, and a mid-burst reset.
module tb_axi1_rd_slave_mem;

  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr_1;
  logic        awvalid_1;
  logic        awready_1;
  logic [63:0] wdata_1;
  logic        wlast_1;
  logic        wvalid_1;
  logic        wready_1;
  logic [31:0] araddr_1;
  logic        arvalid_1;
  logic        arready_1;
  logic [63:0] rdata_1;
  logic        rlast_1;
  logic        rvalid_1;
  logic        rready_1;
  logic        addr_err;
  logic [15:0] wr_bursts;
  logic [15:0] rd_bursts;

  always #5 clk = ~clk;

  axi1_rd_slave_mem dut (
    .clk      (clk),
    .rst      (rst),
    .awaddr_1 (awaddr_1),
    .awvalid_1(awvalid_1),
    .awready_1(awready_1),
    .wdata_1  (wdata_1),
    .wlast_1  (wlast_1),
    .wvalid_1 (wvalid_1),
    .wready_1 (wready_1),
    .araddr_1 (araddr_1),
    .arvalid_1(arvalid_1),
    .arready_1(arready_1),
    .rdata_1  (rdata_1),
    .rlast_1  (rlast_1),
    .rvalid_1 (rvalid_1),
    .rready_1 (rready_1),
    .addr_err (addr_err),
    .wr_bursts(wr_bursts),
    .rd_bursts(rd_bursts)
  );

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    int          n;
    logic [63:0] d0;
    bit          bp;
    logic [63:0] e [LEN];
    bit          err;
  } op_t;

  typedef struct {
    logic [63:0] d;
    bit          last;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_wr   = 0;
  int    exp_rd   = 0;
  beat_t exp_q[$];
  op_t   ops[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one within bound", name);
  endtask

  function automatic op_t mk(bit rd, logic [31:0] a, int n, logic [63:0] d0, bit bp,
                             logic [63:0] e0, logic [63:0] e1, logic [63:0] e2,
                             logic [63:0] e3, bit err);
    op_t o;
    o.rd = rd; o.addr = a; o.n = n; o.d0 = d0; o.bp = bp; o.err = err;
    o.e[0] = e0; o.e[1] = e1; o.e[2] = e2; o.e[3] = e3;
    return o;
  endfunction

  // Scoreboard: every accepted read beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rvalid_1 && rready_1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {63'd0, rvalid_1}, 64'd0);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("rdata", rdata_1, b.d);
        check("rlast", {63'd0, rlast_1}, {63'd0, b.last});
      end
    end
  end

  task automatic wr_burst(input logic [31:0] addr, input int n, input logic [63:0] d0);
    bit ok;
    awaddr_1  = addr;
    awvalid_1 = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (awready_1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("aw_handshake");
    check("wready_idle", {63'd0, wready_1}, 64'd0);
    @(posedge clk); #1;
    awvalid_1 = 1'b0;
    @(negedge clk);
    check("wready_rise", {63'd0, wready_1}, 64'd1);
    check("awready_busy", {63'd0, awready_1}, 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      wdata_1  = d0 + 64'(k);
      wlast_1  = (k == n - 1);
      wvalid_1 = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (wready_1) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("w_handshake");
      @(posedge clk); #1;
    end
    wvalid_1 = 1'b0;
    wlast_1  = 1'b0;
    exp_wr++;
    check("wr_bursts", {48'd0, wr_bursts}, 64'(exp_wr));
    check("awready_back", {63'd0, awready_1}, 64'd1);
    check("wready_done", {63'd0, wready_1}, 64'd0);
  endtask

  task automatic ar_handshake(input logic [31:0] addr);
    bit ok;
    araddr_1  = addr;
    arvalid_1 = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (arready_1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1;
    arvalid_1 = 1'b0;
  endtask

  task automatic rd_burst(input op_t o);
    int          got;
    bit          stalled;
    logic [63:0] held_d;
    logic        held_l;
    beat_t       b;
    for (int k = 0; k < LEN; k++) begin
      b.d = o.e[k];
      b.last = (k == LEN - 1);
      exp_q.push_back(b);
    end
    ar_handshake(o.addr);
    got = 0;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    for (int c = 0; c < 40 && got < LEN; c++) begin
      rready_1 = o.bp ? (c % 2 == 1) : 1'b1;
      @(negedge clk);
      if (c == 0) check("r_latency", {63'd0, rvalid_1}, 64'd1);
      check("arready_busy", {63'd0, arready_1}, 64'd0);
      if (stalled) begin
        check("hold_data", rdata_1, held_d);
        check("hold_last", {63'd0, rlast_1}, {63'd0, held_l});
      end
      stalled = rvalid_1 && !rready_1;
      held_d  = rdata_1;
      held_l  = rlast_1;
      if (rvalid_1 && rready_1) got++;
      @(posedge clk); #1;
    end
    rready_1 = 1'b0;
    if (got < LEN) timeout("r_beats");
    exp_rd++;
    check("rvalid_done", {63'd0, rvalid_1}, 64'd0);
    check("rlast_done", {63'd0, rlast_1}, 64'd0);
    check("arready_back", {63'd0, arready_1}, 64'd1);
    check("rd_bursts", {48'd0, rd_bursts}, 64'(exp_rd));
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected one before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int    got;
    ops[0]  = mk(0, 32'h0800_0000, 4, 64'd1, 0, 0, 0, 0, 0, 0);
    ops[1]  = mk(0, 32'h0800_0000, 1, 64'h1414_4141, 0, 0, 0, 0, 0, 0);
    ops[2]  = mk(1, 32'h0800_0000, 0, 0, 0, 64'h1414_4141, 64'd2, 64'd3, 64'd4, 0);
    ops[3]  = mk(0, 32'h0800_0000, 1, 64'd1, 0, 0, 0, 0, 0, 0);
    ops[4]  = mk(1, 32'h0800_0000, 0, 0, 0, 64'd1, 64'd2, 64'd3, 64'd4, 0);
    ops[5]  = mk(1, 32'h0800_0000, 0, 0, 1, 64'd1, 64'd2, 64'd3, 64'd4, 0);
    ops[6]  = mk(0, 32'h0800_07F8, 3, 64'hCAFE_0000_0000_00A0, 0, 0, 0, 0, 0, 0);
    ops[7]  = mk(1, 32'h0800_07F8, 0, 0, 1, 64'hCAFE_0000_0000_00A0,
                 64'hCAFE_0000_0000_00A1, 64'hCAFE_0000_0000_00A2, 64'd3, 0);
    ops[8]  = mk(0, 32'h07FF_FFF8, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 0, 0, 1);
    ops[9]  = mk(1, 32'h0800_07F8, 0, 0, 0, 64'hCAFE_0000_0000_00A0,
                 64'hCAFE_0000_0000_00A1, 64'hCAFE_0000_0000_00A2, 64'd3, 1);
    ops[10] = mk(1, 32'h0800_0800, 0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 1);
    ops[11] = mk(0, 32'h0800_0013, 2, 64'h5555_0000_0000_0055, 0, 0, 0, 0, 0, 1);
    ops[12] = mk(1, 32'h0800_0000, 0, 0, 0, 64'hCAFE_0000_0000_00A1,
                 64'hCAFE_0000_0000_00A2, 64'h5555_0000_0000_0055,
                 64'h5555_0000_0000_0056, 1);

    rst = 1'b1;
    awaddr_1 = '0; awvalid_1 = 1'b0; wdata_1 = '0; wlast_1 = 1'b0; wvalid_1 = 1'b0;
    araddr_1 = '0; arvalid_1 = 1'b0; rready_1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {63'd0, awready_1}, 64'd0);
    check("rst_wready", {63'd0, wready_1}, 64'd0);
    check("rst_arready", {63'd0, arready_1}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid_1}, 64'd0);
    check("rst_rlast", {63'd0, rlast_1}, 64'd0);
    check("rst_rdata", rdata_1, 64'd0);
    check("rst_addr_err", {63'd0, addr_err}, 64'd0);
    check("rst_wr_bursts", {48'd0, wr_bursts}, 64'd0);
    check("rst_rd_bursts", {48'd0, rd_bursts}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_awready", {63'd0, awready_1}, 64'd1);
    check("idle_arready", {63'd0, arready_1}, 64'd1);

    for (int i = 0; i < 13; i++) begin
      if (ops[i].rd) begin
        rd_burst(ops[i]);
        $display("op %0d: read  addr=%h bp=%0d rd_bursts=%0d", i, ops[i].addr, ops[i].bp, rd_bursts);
      end else begin
        wr_burst(ops[i].addr, ops[i].n, ops[i].d0);
        $display("op %0d: write addr=%h beats=%0d wr_bursts=%0d", i, ops[i].addr, ops[i].n, wr_bursts);
      end
      check("addr_err", {63'd0, addr_err}, {63'd0, ops[i].err});
    end

    // Reset while the read FSM is mid-burst, after two beats were taken.
    b.d = 64'hCAFE_0000_0000_00A1; b.last = 1'b0; exp_q.push_back(b);
    b.d = 64'hCAFE_0000_0000_00A2; b.last = 1'b0; exp_q.push_back(b);
    ar_handshake(32'h0800_0000);
    rready_1 = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (rvalid_1 && rready_1) got++;
      @(posedge clk); #1;
    end
    if (got < 2) timeout("reset_seq_beats");
    check("pre_rst_rvalid", {63'd0, rvalid_1}, 64'd1);
    rst = 1'b1;
    rready_1 = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rvalid", {63'd0, rvalid_1}, 64'd0);
    check("mid_rst_arready", {63'd0, arready_1}, 64'd0);
    check("mid_rst_awready", {63'd0, awready_1}, 64'd0);
    check("mid_rst_wr_bursts", {48'd0, wr_bursts}, 64'd0);
    check("mid_rst_rd_bursts", {48'd0, rd_bursts}, 64'd0);
    check("mid_rst_addr_err", {63'd0, addr_err}, 64'd0);
    check("mid_rst_sb", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    exp_wr = 0;
    exp_rd = 0;
    @(posedge clk); #1;
    check("post_rst_arready", {63'd0, arready_1}, 64'd1);
    $display("reset during read burst: rvalid=%0d rd_bursts=%0d", rvalid_1, rd_bursts);
    rd_burst(mk(1, 32'h0800_0000, 0, 0, 0, 64'hCAFE_0000_0000_00A1,
                64'hCAFE_0000_0000_00A2, 64'h5555_0000_0000_0055,
                64'h5555_0000_0000_0056, 0));
    $display("re-read after reset: rd_bursts=%0d", rd_bursts);
    check("post_rst_addr_err", {63'd0, addr_err}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
